spmv_mem_arbiter: RTL and testbench

Parametrised N-channel memory request arbiter and response router for the SpMV processing element. It merges load/store requests from any number of PE sub-units (MAC write-back, x-vector cache, matrix decoder, ...) into the single MC request port. Arbitration is selectable between fixed priority and round-robin, with per-channel outstanding-load credits. Load tags are rewritten to carry the channel index, and MC responses are demultiplexed back to the issuing channel with the index stripped.

---
 rtl/spmv_mem_arbiter_if.sv | 50 +++++
 rtl/spmv_mem_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_spmv_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_mem_arbiter_if.sv
// Channel-side and memory-controller-side signal bundle of spmv_mem_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface spmv_mem_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 3
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int UT_W = TAG_W - CH_W;

    logic [NUM_CH-1:0]        ch_req_valid;
    logic [NUM_CH-1:0]        ch_req_st;
    logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
    logic [NUM_CH*DATA_W-1:0] ch_req_d_or_tag;
    logic [NUM_CH-1:0]        ch_req_ready;

    logic                     req_mem_ld;
    logic                     req_mem_st;
    logic [ADDR_W-1:0]        req_mem_addr;
    logic [DATA_W-1:0]        req_mem_d_or_tag;
    logic                     req_mem_stall;

    logic                     rsp_mem_push;
    logic [TAG_W-1:0]         rsp_mem_tag;
    logic [DATA_W-1:0]        rsp_mem_q;
    logic                     rsp_mem_stall;

    logic [NUM_CH-1:0]        ch_rsp_push;
    logic [UT_W-1:0]          ch_rsp_tag;
    logic [DATA_W-1:0]        ch_rsp_q;
    logic [NUM_CH-1:0]        ch_rsp_stall;

    logic                     busy;
    logic                     tag_err;

    modport slave (
        input  ch_req_valid, ch_req_st, ch_req_addr, ch_req_d_or_tag,
        input  req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q, ch_rsp_stall,
        output ch_req_ready, req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
        output rsp_mem_stall, ch_rsp_push, ch_rsp_tag, ch_rsp_q, busy, tag_err
    );

    modport master (
        output ch_req_valid, ch_req_st, ch_req_addr, ch_req_d_or_tag,
        output req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q, ch_rsp_stall,
        input  ch_req_ready, req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
        input  rsp_mem_stall, ch_rsp_push, ch_rsp_tag, ch_rsp_q, busy, tag_err
    );
endinterface

// File: rtl/spmv_mem_arbiter.sv
// N-channel MC request arbiter with per-channel load credits and tag rewriting,
// plus the response router that returns MC data to the issuing channel.
module spmv_mem_arbiter #(
    parameter int NUM_CH            = 3,
    parameter int ADDR_W            = 48,
    parameter int DATA_W            = 64,
    parameter int TAG_W             = 3,
    parameter int DEPTH             = 32,
    parameter int ALMOST_FULL_COUNT = 4,
    parameter int MAX_OUTSTANDING   = 16,
    parameter int RR_MODE           = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    spmv_mem_arbiter_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int UT_W  = TAG_W - CH_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENT_W = DATA_W + ADDR_W + 2;

    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - ALMOST_FULL_COUNT);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(MAX_OUTSTANDING);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

    logic [CRD_W-1:0]  credit [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_vld;
    logic [CH_W-1:0]   last_grant;

    logic              sel_st;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_d;
    logic [TAG_W-1:0]  ld_tag;
    logic [DATA_W-1:0] wr_d;
    logic [ENT_W-1:0]  wr_ent;
    logic [ENT_W-1:0]  rd_ent;

    logic [ENT_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              almost_full;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              stall_r;

    logic [CH_W-1:0]   rsp_idx;
    logic              rsp_idx_ok;
    logic              rsp_route;
    logic              any_credit;

    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full   = (fifo_cnt == FULL_LVL);
    assign almost_full = (fifo_cnt >= AF_LEVEL);

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = bus.ch_req_valid[i] && !almost_full &&
                          (bus.ch_req_st[i] || (credit[i] < CRD_MAX));
        end
    end

    // Both searches are written so the last assignment is the winner.
    always_comb begin
        int cand;
        cand      = 0;
        grant_idx = '0;
        grant_vld = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = int'(last_grant) + k;
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end
                if (eligible[cand]) begin
                    grant_idx = CH_W'(cand);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grant_idx = CH_W'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign grant            = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;
    assign bus.ch_req_ready = grant;
    assign fifo_wr          = grant_vld && !fifo_full;
    assign fifo_rd          = !fifo_empty && !stall_r;

    always_comb begin
        sel_st   = 1'b0;
        sel_addr = '0;
        sel_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_st   = bus.ch_req_st[i];
                sel_addr = bus.ch_req_addr[i*ADDR_W +: ADDR_W];
                sel_d    = bus.ch_req_d_or_tag[i*DATA_W +: DATA_W];
            end
        end
    end

    // Loads carry the channel index in the low tag bits so responses can be routed back.
    assign ld_tag = {sel_d[UT_W-1:0], grant_idx};
    assign wr_d   = sel_st ? sel_d : DATA_W'(ld_tag);
    assign wr_ent = {wr_d, sel_addr, sel_st, ~sel_st};
    assign rd_ent = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= wr_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (grant_vld) begin
                last_grant <= grant_idx;
            end
        end
    end

    // Address and data hold their last issued value between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r              <= 1'b0;
            bus.req_mem_ld       <= 1'b0;
            bus.req_mem_st       <= 1'b0;
            bus.req_mem_addr     <= '0;
            bus.req_mem_d_or_tag <= '0;
        end else begin
            stall_r        <= bus.req_mem_stall;
            bus.req_mem_ld <= fifo_rd && rd_ent[0];
            bus.req_mem_st <= fifo_rd && rd_ent[1];
            if (fifo_rd) begin
                bus.req_mem_addr     <= rd_ent[2 +: ADDR_W];
                bus.req_mem_d_or_tag <= rd_ent[ADDR_W+2 +: DATA_W];
            end
        end
    end

    assign rsp_idx    = bus.rsp_mem_tag[CH_W-1:0];
    assign rsp_idx_ok = ({1'b0, rsp_idx} < CH_LIMIT);
    assign rsp_route  = bus.rsp_mem_push && rsp_idx_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                credit[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case ({fifo_wr && grant[i] && !bus.ch_req_st[i],
                       rsp_route && (rsp_idx == CH_W'(i)) && (credit[i] != '0)})
                    2'b10:   credit[i] <= credit[i] + CRD_W'(1);
                    2'b01:   credit[i] <= credit[i] - CRD_W'(1);
                    default: credit[i] <= credit[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ch_rsp_push   <= '0;
            bus.ch_rsp_tag    <= '0;
            bus.ch_rsp_q      <= '0;
            bus.rsp_mem_stall <= 1'b0;
            bus.tag_err       <= 1'b0;
        end else begin
            bus.ch_rsp_push   <= rsp_route ? (NUM_CH'(1) << rsp_idx) : '0;
            bus.ch_rsp_tag    <= bus.rsp_mem_tag[TAG_W-1:CH_W];
            bus.ch_rsp_q      <= bus.rsp_mem_q;
            bus.rsp_mem_stall <= |bus.ch_rsp_stall;
            if (bus.rsp_mem_push && !rsp_idx_ok) begin
                bus.tag_err <= 1'b1;
            end
        end
    end

    always_comb begin
        any_credit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            any_credit = any_credit | (credit[i] != '0);
        end
    end

    assign bus.busy = !fifo_empty || any_credit || (|bus.ch_req_valid);

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed bench for spmv_mem_arbiter: a fixed-priority and a round-robin instance,
// with issued MC requests checked in order against an expected-request queue.
`timescale 1ns/1ps
module tb_spmv_mem_arbiter;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 3;

    typedef struct packed {
        logic              ld;
        logic              st;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] d;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int issues_fp = 0;
    int issues_rr = 0;
    req_t exp_fp[$];
    req_t exp_rr[$];
    req_t e_fp;
    req_t e_rr;

    spmv_mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) ifp ();
    spmv_mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) irr ();

    spmv_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .DEPTH(8), .ALMOST_FULL_COUNT(3), .MAX_OUTSTANDING(16), .RR_MODE(0)
    ) dut_fp (.clk(clk), .rst_n(rst_n), .bus(ifp.slave));

    spmv_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .DEPTH(32), .ALMOST_FULL_COUNT(4), .MAX_OUTSTANDING(2), .RR_MODE(1)
    ) dut_rr (.clk(clk), .rst_n(rst_n), .bus(irr.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (ifp.req_mem_ld || ifp.req_mem_st)) begin
            issues_fp++;
            check("fp_sb_nonempty", 64'(exp_fp.size() != 0), 64'd1);
            if (exp_fp.size() != 0) begin
                e_fp = exp_fp.pop_front();
                check("fp_sb_ld", ifp.req_mem_ld, e_fp.ld);
                check("fp_sb_st", ifp.req_mem_st, e_fp.st);
                check("fp_sb_addr", ifp.req_mem_addr, e_fp.addr);
                check("fp_sb_data", ifp.req_mem_d_or_tag, e_fp.d);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (irr.req_mem_ld || irr.req_mem_st)) begin
            issues_rr++;
            check("rr_sb_nonempty", 64'(exp_rr.size() != 0), 64'd1);
            if (exp_rr.size() != 0) begin
                e_rr = exp_rr.pop_front();
                check("rr_sb_ld", irr.req_mem_ld, e_rr.ld);
                check("rr_sb_st", irr.req_mem_st, e_rr.st);
                check("rr_sb_addr", irr.req_mem_addr, e_rr.addr);
                check("rr_sb_data", irr.req_mem_d_or_tag, e_rr.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq;
        int snap_a;
        int snap_b;
        int waited;

        ifp.ch_req_valid = '0; ifp.ch_req_st = '0; ifp.ch_req_addr = '0; ifp.ch_req_d_or_tag = '0;
        ifp.req_mem_stall = 1'b0; ifp.rsp_mem_push = 1'b0; ifp.rsp_mem_tag = '0; ifp.rsp_mem_q = '0;
        ifp.ch_rsp_stall = '0;
        irr.ch_req_valid = '0; irr.ch_req_st = '0; irr.ch_req_addr = '0; irr.ch_req_d_or_tag = '0;
        irr.req_mem_stall = 1'b0; irr.rsp_mem_push = 1'b0; irr.rsp_mem_tag = '0; irr.rsp_mem_q = '0;
        irr.ch_rsp_stall = '0;
        seq = 0; snap_a = 0; snap_b = 0; waited = 0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_fp_ld", ifp.req_mem_ld, 1'b0);
        check("rst_fp_st", ifp.req_mem_st, 1'b0);
        check("rst_fp_addr", ifp.req_mem_addr, 48'h0);
        check("rst_fp_busy", ifp.busy, 1'b0);
        check("rst_fp_tag_err", ifp.tag_err, 1'b0);
        check("rst_rr_push", irr.ch_rsp_push, 3'b000);
        check("rst_rr_stall", irr.rsp_mem_stall, 1'b0);
        rst_n = 1'b1;

        // fixed priority: ch0 and ch2 loads, only ch0 may win
        step();
        ifp.ch_req_valid = 3'b101;
        ifp.ch_req_st = 3'b000;
        ifp.ch_req_addr = {48'h300, 48'h0, 48'h100};
        ifp.ch_req_d_or_tag = {64'h1, 64'h0, 64'h1};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("fp_prio_ready", ifp.ch_req_ready, 3'b001);
            exp_fp.push_back('{ld: 1'b1, st: 1'b0, addr: 48'h100, d: 64'h4});
            if (c == 1) check("fp_lat_cycle1_idle", ifp.req_mem_ld, 1'b0);
            if (c == 2) check("fp_lat_cycle2_issue", ifp.req_mem_ld, 1'b1);
            step();
        end
        ifp.ch_req_valid = 3'b000;
        repeat (3) step();
        @(negedge clk);
        check("fp_drained", exp_fp.size(), 0);
        check("fp_addr_hold", ifp.req_mem_addr, 48'h100);
        check("fp_busy_credits", ifp.busy, 1'b1);

        // return the six ch0 loads
        for (int i = 0; i < 6; i++) begin
            step();
            ifp.rsp_mem_push = 1'b1; ifp.rsp_mem_tag = 3'b100; ifp.rsp_mem_q = 64'hD000 + 64'(i);
            step();
            ifp.rsp_mem_push = 1'b0;
            @(negedge clk);
            check("fp_rsp_push", ifp.ch_rsp_push, 3'b001);
            check("fp_rsp_tag", ifp.ch_rsp_tag, 1'b1);
            check("fp_rsp_q", ifp.ch_rsp_q, 64'hD000 + 64'(i));
        end
        step();
        @(negedge clk);
        check("fp_busy_idle", ifp.busy, 1'b0);

        // round robin: three store channels rotate 0,1,2
        step();
        irr.ch_req_valid = 3'b111;
        irr.ch_req_st = 3'b111;
        irr.ch_req_addr = {48'h1002, 48'h1001, 48'h1000};
        irr.ch_req_d_or_tag = {64'hA2, 64'hA1, 64'hA0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_grant", irr.ch_req_ready, 3'b001 << (k % 3));
            exp_rr.push_back('{ld: 1'b0, st: 1'b1, addr: 48'h1000 + 48'(k % 3), d: 64'hA0 + 64'(k % 3)});
            step();
        end
        irr.ch_req_valid = 3'b000;
        repeat (4) step();
        @(negedge clk);
        check("rr_drained", exp_rr.size(), 0);

        // credit limit of 2 on ch1
        step();
        irr.ch_req_valid = 3'b010;
        irr.ch_req_st = 3'b000;
        irr.ch_req_addr = {48'h0, 48'h2000, 48'h0};
        irr.ch_req_d_or_tag = '0;
        @(negedge clk);
        check("crd_load1", irr.ch_req_ready, 3'b010);
        exp_rr.push_back('{ld: 1'b1, st: 1'b0, addr: 48'h2000, d: 64'h1});
        step();
        @(negedge clk);
        check("crd_load2", irr.ch_req_ready, 3'b010);
        exp_rr.push_back('{ld: 1'b1, st: 1'b0, addr: 48'h2000, d: 64'h1});
        step();
        @(negedge clk);
        check("crd_blocked", irr.ch_req_ready, 3'b000);
        check("crd_busy", irr.busy, 1'b1);
        step();
        irr.rsp_mem_push = 1'b1; irr.rsp_mem_tag = 3'b001; irr.rsp_mem_q = 64'hBEEF;
        @(negedge clk);
        check("crd_same_cycle_blocked", irr.ch_req_ready, 3'b000);
        step();
        irr.rsp_mem_push = 1'b0;
        @(negedge clk);
        check("crd_freed", irr.ch_req_ready, 3'b010);
        check("crd_rsp_push", irr.ch_rsp_push, 3'b010);
        check("crd_rsp_tag", irr.ch_rsp_tag, 1'b0);
        check("crd_rsp_q", irr.ch_rsp_q, 64'hBEEF);
        exp_rr.push_back('{ld: 1'b1, st: 1'b0, addr: 48'h2000, d: 64'h1});
        step();
        irr.ch_req_valid = 3'b000;

        // tag 0b101 -> ch1 with user tag 1, twice to clear ch1 credits
        for (int i = 0; i < 2; i++) begin
            step();
            irr.rsp_mem_push = 1'b1; irr.rsp_mem_tag = 3'b101; irr.rsp_mem_q = 64'h77 + 64'(i);
            step();
            irr.rsp_mem_push = 1'b0;
            @(negedge clk);
            check("rsp101_push", irr.ch_rsp_push, 3'b010);
            check("rsp101_tag", irr.ch_rsp_tag, 1'b1);
        end

        // out-of-range index 3 sets the sticky error and routes nothing
        step();
        irr.rsp_mem_push = 1'b1; irr.rsp_mem_tag = 3'b111; irr.rsp_mem_q = 64'h55;
        @(negedge clk);
        check("tagerr_before", irr.tag_err, 1'b0);
        step();
        irr.rsp_mem_push = 1'b0;
        @(negedge clk);
        check("tagerr_no_push", irr.ch_rsp_push, 3'b000);
        check("tagerr_set", irr.tag_err, 1'b1);
        repeat (3) step();
        @(negedge clk);
        check("tagerr_sticky", irr.tag_err, 1'b1);
        check("rr_busy_idle", irr.busy, 1'b0);
        check("rr_drained2", exp_rr.size(), 0);

        // rsp_mem_stall lags the OR of ch_rsp_stall by one cycle
        step();
        irr.ch_rsp_stall = 3'b100;
        @(negedge clk);
        check("rspstall_lag0", irr.rsp_mem_stall, 1'b0);
        step();
        irr.ch_rsp_stall = 3'b000;
        @(negedge clk);
        check("rspstall_lag1", irr.rsp_mem_stall, 1'b1);
        step();
        @(negedge clk);
        check("rspstall_release", irr.rsp_mem_stall, 1'b0);

        // MC stall under full store load on the fixed-priority instance (threshold 5)
        seq = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            if (cyc == 0) begin
                ifp.ch_req_valid = 3'b111;
                ifp.ch_req_st = 3'b111;
                ifp.ch_req_addr = {48'h502, 48'h501, 48'h500};
                ifp.ch_req_d_or_tag = {64'hEE2, 64'hEE1, 64'h0};
            end
            if (cyc == 4) ifp.req_mem_stall = 1'b1;
            if (cyc == 5) snap_a = issues_fp;
            if (cyc == 14) ifp.req_mem_stall = 1'b0;
            if (cyc == 15) snap_b = issues_fp;
            if (cyc == 24) ifp.ch_req_valid = 3'b000;
            ifp.ch_req_d_or_tag[DATA_W-1:0] = 64'(seq);
            @(negedge clk);
            check("stall_no_low_prio", 64'(ifp.ch_req_ready[2:1]), 64'd0);
            if (cyc == 8)  check("stall_ready_below_thr", ifp.ch_req_ready[0], 1'b1);
            if (cyc == 9)  check("stall_ready_at_thr", ifp.ch_req_ready[0], 1'b0);
            if (cyc == 15) check("stall_resume_not_yet", ifp.req_mem_st, 1'b0);
            if (cyc == 16) check("stall_resume_issue", ifp.req_mem_st, 1'b1);
            if (cyc == 16) check("stall_ready_reopen", ifp.ch_req_ready[0], 1'b1);
            if (ifp.ch_req_ready[0]) begin
                exp_fp.push_back('{ld: 1'b0, st: 1'b1, addr: 48'h500, d: 64'(seq)});
                seq++;
            end
        end
        check("stall_issues_after_rise", 64'((snap_b - snap_a) <= 2), 64'd1);
        waited = 0;
        while (exp_fp.size() != 0 && waited < 40) begin
            step();
            waited++;
        end
        check("stall_all_issued", exp_fp.size(), 0);
        step();
        @(negedge clk);
        check("stall_busy_idle", ifp.busy, 1'b0);

        // queue five stores behind a stall, then reset mid-operation
        step();
        ifp.req_mem_stall = 1'b1;
        step();
        step();
        ifp.ch_req_valid = 3'b001;
        ifp.ch_req_st = 3'b001;
        ifp.ch_req_addr = {48'h0, 48'h0, 48'h700};
        ifp.ch_req_d_or_tag = {64'h0, 64'h0, 64'hDEAD};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_fill_ready", ifp.ch_req_ready, 3'b001);
            step();
        end
        ifp.ch_req_valid = 3'b000;
        @(negedge clk);
        check("rst_fill_full", ifp.ch_req_ready, 3'b000);
        check("rst_fill_busy", ifp.busy, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_ld", ifp.req_mem_ld, 1'b0);
        check("rstmid_st", ifp.req_mem_st, 1'b0);
        check("rstmid_addr", ifp.req_mem_addr, 48'h0);
        check("rstmid_data", ifp.req_mem_d_or_tag, 64'h0);
        check("rstmid_busy", ifp.busy, 1'b0);
        check("rstmid_rr_tag_err", irr.tag_err, 1'b0);
        check("rstmid_rsp_q", ifp.ch_rsp_q, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ifp.req_mem_stall = 1'b0;
        snap_a = issues_fp;
        repeat (8) step();
        @(negedge clk);
        check("rst_no_stale_issue", issues_fp - snap_a, 0);
        check("rst_busy_after", ifp.busy, 1'b0);
        check("rst_ready_idle", ifp.ch_req_ready, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
